image_frame_loader: RTL and testbench
=====================================

Name: image_frame_loader

Overview:
- Upstream stage of the concurrent-processor halftone converter.
- Accepts a raster-order pixel stream over a valid/ready handshake and assembles one full N_col x M_row frame into the flat pixel_bits bus.
- Issues a single-cycle Go when the converter reports Done, then holds off new input until the conversion completes.
- Provides frame-error and frame-count status for the host side.

Parameters:
pixel_size, 8, bits per pixel
N_col, 8, pixels per row
M_row, 6, rows per frame
BUSY_TIMEOUT, 4, max cycles after Go for converter Done to drop before declaring error

Ports:
clk_i  input  1  single system clock, rising edge
rst_i  input  1  asynchronous active-high reset
s_pixel  input  pixel_size  stream pixel value
s_valid  input  1  s_pixel/s_last valid
s_last  input  1  marks final pixel of a frame
s_ready  output  1  loader can accept a pixel
pixel_bits  output  [1:N_col*M_row*pixel_size]  assembled frame to converter
Go  output  1  one-cycle launch strobe to converter
Done_i  input  1  converter idle flag (high when idle)
busy  output  1  frame launched, conversion not yet finished
frame_err  output  1  one-cycle pulse on framing/timeout error
frame_cnt  output  16  frames successfully launched, wraps 0xFFFF->0

Behaviour:
- Reset (async, rst_i=1): state FILL, pixel counter 0, pixel_bits all 0, Go 0, busy 0, frame_err 0, frame_cnt 0. s_ready 0 while rst_i is high.
- Reset mid-operation discards any partial frame. Go drops immediately.
- Handshake: a pixel transfers on a rising edge with s_valid=1 and s_ready=1. s_ready=1 only in FILL. s_ready does not depend combinationally on s_valid.
- Placement: pixel k (0-based raster index, k = (row-1)*N_col + (col-1)) is written to pixel_bits[k*pixel_size+1 +: pixel_size]. This is the converter's row-major layout.
- Counter width is ceil(log2(N_col*M_row)) bits.
- States:
  - FILL: accept pixels.
    - Transfer with count = N*M-1 goes to LAUNCH and the counter clears. If s_last=0 on that pixel, pulse frame_err; the frame is still launched.
    - Transfer with s_last=1 and count < N*M-1 pulses frame_err, clears the counter and stays in FILL (partial frame dropped). pixel_bits is not cleared.
  - LAUNCH: s_ready=0, pixel_bits frozen.
    - Go = Done_i (combinational from state); leave to WAIT_BUSY on the edge where Done_i=1.
    - frame_cnt increments on that same edge.
  - WAIT_BUSY: busy=1.
    - Done_i=0 goes to WAIT_DONE.
    - After BUSY_TIMEOUT cycles with Done_i still 1: pulse frame_err, go to FILL.
  - WAIT_DONE: busy=1. Done_i=1 goes to FILL; s_ready=1 on the next cycle.
- pixel_bits changes only on FILL transfers, so it is stable from LAUNCH through the converter load edge.
- Latency:
  - Final pixel edge t -> Go high during cycle t+1, provided Done_i=1.
  - Best-case frame-to-frame gap = N*M transfers + 1 LAUNCH + converter busy time + 1.
- Simultaneous events:
  - s_valid during LAUNCH/WAIT_* is ignored (not accepted, s_ready=0).
  - frame_err and the LAUNCH entry may coincide (missing s_last case).
- frame_err is registered and high for exactly one cycle per error event.

Test Plan:
- Reset then stream 48 pixels k=0..47 with value k+1, s_last on the 48th, Done_i=1 -> Go high exactly one cycle, one cycle after 48th transfer; pixel_bits[1:8]=8'd1, pixel_bits[377:384]=8'd48; frame_cnt=1; no frame_err.
- Same stream but Done_i=0 for 5 cycles at LAUNCH -> Go stays 0, s_ready 0, pixel_bits unchanged; Go pulses on first cycle Done_i=1.
- s_last asserted on pixel 20 -> frame_err one-cycle pulse, no Go, next pixel lands at k=0, frame_cnt unchanged.
- 48 pixels without s_last -> frame_err pulse coincident with LAUNCH entry, Go still issued, frame_cnt=1.
- After Go, hold Done_i=1 for 4 cycles -> frame_err pulse, busy returns 0, s_ready=1; Done_i low 18 cycles then high (normal case) -> busy=1 throughout, s_ready=1 one cycle after Done_i rises.
- Assert rst_i asynchronously mid-fill (pixel 30) and mid-WAIT_DONE -> all outputs cleared without clock edge, next frame loads from k=0 correctly.

Source files
------------

// File: rtl/image_frame_loader_if.sv
// Pixel stream handshake between the upstream source and the frame loader.
// Source drives pixel/valid/last, loader returns ready.
interface image_frame_loader_if #(
    parameter int pixel_size = 8
);
    logic [pixel_size-1:0] s_pixel;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    modport master (
        output s_pixel,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_pixel,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/image_frame_loader.sv
// Frame loader: assembles a raster pixel stream into one flat frame,
// launches the halftone converter and tracks its busy/done cycle.
module image_frame_loader #(
    parameter int pixel_size   = 8,
    parameter int N_col        = 8,
    parameter int M_row        = 6,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    image_frame_loader_if.slave             s,
    output logic [1:N_col*M_row*pixel_size] pixel_bits,
    output logic                            Go,
    input  logic                            Done_i,
    output logic                            busy,
    output logic                            frame_err,
    output logic [15:0]                     frame_cnt
);

    localparam int NPIX = N_col * M_row;
    localparam int CW   = $clog2(NPIX);
    localparam int TW   = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [TW-1:0]  tmo;
    logic           xfer;

    assign s.s_ready = (state == FILL) && !rst_i;
    assign xfer      = s.s_valid && s.s_ready;
    assign Go        = (state == LAUNCH) && Done_i;
    assign busy      = (state == WAIT_BUSY) || (state == WAIT_DONE);

    // Frame fill, launch and converter-handshake sequencing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= FILL;
            cnt        <= '0;
            tmo        <= '0;
            pixel_bits <= '0;
            frame_err  <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                FILL: begin
                    if (xfer) begin
                        for (int k = 0; k < NPIX; k++) begin
                            if (cnt == CW'(k))
                                pixel_bits[k*pixel_size+1 +: pixel_size]
                                    <= s.s_pixel;
                        end
                        if (cnt == CW'(NPIX - 1)) begin
                            cnt       <= '0;
                            state     <= LAUNCH;
                            frame_err <= !s.s_last;
                        end else if (s.s_last) begin
                            cnt       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    if (Done_i) begin
                        state     <= WAIT_BUSY;
                        tmo       <= '0;
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                WAIT_BUSY: begin
                    if (!Done_i) begin
                        state <= WAIT_DONE;
                    end else if (tmo == TW'(BUSY_TIMEOUT - 1)) begin
                        state     <= FILL;
                        frame_err <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (Done_i)
                        state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_image_frame_loader.sv
// Self-checking bench for image_frame_loader: directed steps with
// random pixel data checked against a frame-memory model.
module tb_image_frame_loader;

    localparam int PS   = 8;
    localparam int NC   = 8;
    localparam int MR   = 6;
    localparam int NPIX = NC * MR;
    localparam int NB   = NPIX * PS;
    localparam int BT   = 4;

    logic           clk_i  = 1'b0;
    logic           rst_i  = 1'b0;
    logic           Done_i = 1'b1;
    logic [1:NB]    pixel_bits;
    logic           Go;
    logic           busy;
    logic           frame_err;
    logic [15:0]    frame_cnt;

    image_frame_loader_if #(.pixel_size(PS)) sif ();

    image_frame_loader #(
        .pixel_size  (PS),
        .N_col       (NC),
        .M_row       (MR),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s         (sif),
        .pixel_bits(pixel_bits),
        .Go        (Go),
        .Done_i    (Done_i),
        .busy      (busy),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] mem [NPIX];
    int         fill_n  = 0;
    int         exp_cnt = 0;

    function automatic logic [NB-1:0] exp_bits();
        logic [1:NB] r;
        for (int k = 0; k < NPIX; k++)
            r[k*PS+1 +: PS] = mem[k];
        return r;
    endfunction

    task automatic chk(input string tag,
                       input logic [NB-1:0] obs,
                       input logic [NB-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NPIX; k++)
            mem[k] = 8'd0;
        fill_n  = 0;
        exp_cnt = 0;
    endtask

    task automatic send_pixel(input logic [7:0] v, input bit last);
        sif.s_pixel = v;
        sif.s_valid = 1'b1;
        sif.s_last  = last;
        chk("s_ready_fill", sif.s_ready, 1'b1);
        tick();
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        mem[fill_n] = v;
        if (fill_n == NPIX - 1 || last)
            fill_n = 0;
        else
            fill_n++;
    endtask

    task automatic send_frame(input int n, input bit last_flag,
                              input bit seq);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            if (!seq && $urandom_range(0, 3) == 0)
                tick();
            v = seq ? 8'(i + 1) : 8'($urandom);
            send_pixel(v, last_flag && (i == n - 1));
        end
    endtask

    // Called in LAUNCH: stall lat cycles, then launch and run a
    // converter busy period of busy_len cycles.
    task automatic complete(input int lat, input int busy_len);
        for (int i = 0; i < lat; i++) begin
            Done_i      = 1'b0;
            sif.s_valid = 1'b1;
            sif.s_pixel = 8'($urandom);
            #1;
            chk("go_stall", Go, 1'b0);
            chk("ready_stall", sif.s_ready, 1'b0);
            tick();
        end
        sif.s_valid = 1'b0;
        Done_i = 1'b1;
        #1;
        chk("go_pulse", Go, 1'b1);
        chk("bits_launch", pixel_bits, exp_bits());
        tick();
        exp_cnt++;
        chk("go_drop", Go, 1'b0);
        chk("frame_cnt", frame_cnt, 16'(exp_cnt));
        chk("busy_start", busy, 1'b1);
        Done_i = 1'b0;
        for (int i = 0; i < busy_len; i++) begin
            tick();
            chk("busy_hold", busy, 1'b1);
            chk("ready_busy", sif.s_ready, 1'b0);
        end
        Done_i = 1'b1;
        tick();
        chk("busy_end", busy, 1'b0);
        chk("ready_back", sif.s_ready, 1'b1);
        chk("bits_kept", pixel_bits, exp_bits());
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, sif.s_ready, 1'b0);
        chk({tag, "_go"}, Go, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, frame_err, 1'b0);
        chk({tag, "_cnt"}, frame_cnt, 16'd0);
        chk({tag, "_bits"}, pixel_bits, '0);
    endtask

    initial begin
        sif.s_pixel = '0;
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        model_reset();

        // Power-on reset, checked before any clock edge.
        #1 rst_i = 1'b1;
        #1;
        chk_reset_outputs("por");
        tick();
        tick();
        #2 rst_i = 1'b0;

        // Sequential frame k+1, converter idle.
        tick();
        send_frame(NPIX, 1'b1, 1'b1);
        chk("f1_err", frame_err, 1'b0);
        chk("f1_first", pixel_bits[1:8], 8'd1);
        chk("f1_last", pixel_bits[377:384], 8'd48);
        complete(0, 18);

        // Random frame, converter slow to report idle.
        send_frame(NPIX, 1'b1, 1'b0);
        chk("f2_err", frame_err, 1'b0);
        complete(5, 3);

        // Early s_last on pixel 20 drops the partial frame.
        send_frame(20, 1'b1, 1'b0);
        chk("early_err", frame_err, 1'b1);
        chk("early_go", Go, 1'b0);
        chk("early_ready", sif.s_ready, 1'b1);
        chk("early_cnt", frame_cnt, 16'(exp_cnt));
        tick();
        chk("early_err_drop", frame_err, 1'b0);
        send_frame(NPIX, 1'b1, 1'b0);
        chk("refill_err", frame_err, 1'b0);
        complete(0, 6);

        // Full frame without s_last, then converter never goes busy.
        send_frame(NPIX, 1'b0, 1'b0);
        chk("nolast_err", frame_err, 1'b1);
        chk("nolast_go", Go, 1'b1);
        chk("nolast_bits", pixel_bits, exp_bits());
        tick();
        exp_cnt++;
        chk("nolast_err_drop", frame_err, 1'b0);
        chk("nolast_cnt", frame_cnt, 16'(exp_cnt));
        for (int i = 0; i < BT - 1; i++) begin
            tick();
            chk("tmo_busy", busy, 1'b1);
            chk("tmo_noerr", frame_err, 1'b0);
        end
        tick();
        chk("tmo_err", frame_err, 1'b1);
        chk("tmo_busy_drop", busy, 1'b0);
        chk("tmo_ready", sif.s_ready, 1'b1);
        tick();
        chk("tmo_err_drop", frame_err, 1'b0);

        // Asynchronous reset in the middle of a fill.
        send_frame(30, 1'b0, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        chk_reset_outputs("rst_fill");
        #1 rst_i = 1'b0;
        tick();
        send_frame(NPIX, 1'b1, 1'b0);
        chk("post_rst_err", frame_err, 1'b0);
        chk("post_rst_go", Go, 1'b1);
        chk("post_rst_bits", pixel_bits, exp_bits());

        // Launch, enter WAIT_DONE, then reset asynchronously.
        tick();
        exp_cnt++;
        chk("wd_cnt", frame_cnt, 16'(exp_cnt));
        Done_i = 1'b0;
        tick();
        tick();
        chk("wd_busy", busy, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        chk_reset_outputs("rst_wd");
        #1 rst_i = 1'b0;
        Done_i = 1'b1;
        tick();

        // Clean frame after reset.
        send_frame(NPIX, 1'b1, 1'b0);
        chk("final_err", frame_err, 1'b0);
        complete(2, 4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
